// File: rtl/cpu_pkg.sv
// Shared CPU constants: datapath widths, instruction register-field positions
// and the hardwired zero register, plus field extraction helpers.
package cpu_pkg;

    localparam int DATA_W  = 32;
    localparam int ADDR_W  = 5;
    localparam int INSTR_W = 32;

    localparam int RS_MSB = 25;
    localparam int RS_LSB = 21;
    localparam int RT_MSB = 20;
    localparam int RT_LSB = 16;

    localparam logic [ADDR_W-1:0] REG_ZERO = 5'd0;

    function automatic logic [ADDR_W-1:0] rs_field(input logic [INSTR_W-1:0] instr);
        return instr[RS_MSB:RS_LSB];
    endfunction

    function automatic logic [ADDR_W-1:0] rt_field(input logic [INSTR_W-1:0] instr);
        return instr[RT_MSB:RT_LSB];
    endfunction

endpackage

// File: rtl/operand_fetch_if.sv
// Bus bundle around operand_fetch: decode handshake, register-file read port,
// writeback snoop and execute handshake. slave = operand_fetch, master = environment.
interface operand_fetch_if #(
    parameter int DATA_W  = cpu_pkg::DATA_W,
    parameter int ADDR_W  = cpu_pkg::ADDR_W,
    parameter int INSTR_W = cpu_pkg::INSTR_W
);

    logic               in_valid;
    logic               in_ready;
    logic [INSTR_W-1:0] in_instr;
    logic               flush;

    logic [ADDR_W-1:0]  rf_rs;
    logic [ADDR_W-1:0]  rf_rt;
    logic [DATA_W-1:0]  rf_rs_data;
    logic [DATA_W-1:0]  rf_rt_data;

    logic               wb_we;
    logic [ADDR_W-1:0]  wb_addr;
    logic [DATA_W-1:0]  wb_data;

    logic               out_valid;
    logic               out_ready;
    logic [INSTR_W-1:0] out_instr;
    logic [DATA_W-1:0]  out_a;
    logic [DATA_W-1:0]  out_b;

    modport slave (
        input  in_valid, in_instr, flush,
        input  rf_rs_data, rf_rt_data,
        input  wb_we, wb_addr, wb_data,
        input  out_ready,
        output in_ready,
        output rf_rs, rf_rt,
        output out_valid, out_instr, out_a, out_b
    );

    modport master (
        output in_valid, in_instr, flush,
        output rf_rs_data, rf_rt_data,
        output wb_we, wb_addr, wb_data,
        output out_ready,
        input  in_ready,
        input  rf_rs, rf_rt,
        input  out_valid, out_instr, out_a, out_b
    );

endinterface

// File: rtl/operand_fetch_rf_bypass_port.sv
// One register-file read port with writeback snoop: remembers a write that lands
// on the address being read, since the registered regfile still returns the old value.
module rf_bypass_port #(
    parameter int DATA_W = cpu_pkg::DATA_W,
    parameter int ADDR_W = cpu_pkg::ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] i_rd_addr,
    input  logic [ADDR_W-1:0] i_held_addr,
    input  logic              i_flush,
    input  logic              i_wb_we,
    input  logic [ADDR_W-1:0] i_wb_addr,
    input  logic [DATA_W-1:0] i_wb_data,
    input  logic [DATA_W-1:0] i_rf_data,
    output logic              o_hit,
    output logic [DATA_W-1:0] o_operand
);
    import cpu_pkg::*;

    logic              w_hit;
    logic              r_ovr;
    logic [DATA_W-1:0] r_ovr_data;

    assign w_hit = i_wb_we & (i_wb_addr == i_rd_addr) & (i_rd_addr != ADDR_W'(REG_ZERO));
    assign o_hit = w_hit;

    // Override flag follows this edge's hit; data is only captured on a hit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ovr      <= 1'b0;
            r_ovr_data <= {DATA_W{1'b0}};
        end else begin
            r_ovr <= w_hit & ~i_flush;
            if (w_hit) begin
                r_ovr_data <= i_wb_data;
            end else begin
                r_ovr_data <= r_ovr_data;
            end
        end
    end

    // Register zero reads as zero regardless of what the regfile or snoop say.
    always_comb begin
        o_operand = {DATA_W{1'b0}};
        if (i_held_addr == ADDR_W'(REG_ZERO)) begin
            o_operand = {DATA_W{1'b0}};
        end else if (r_ovr) begin
            o_operand = r_ovr_data;
        end else begin
            o_operand = i_rf_data;
        end
    end

endmodule

// File: rtl/operand_fetch.sv
// Operand fetch stage: single-entry decode->execute register that reads rs/rt
// from a 1-cycle registered regfile and patches the read-during-write gap.
module operand_fetch #(
    parameter int DATA_W = cpu_pkg::DATA_W,
    parameter int ADDR_W = cpu_pkg::ADDR_W,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    operand_fetch_if.slave    bus,
    output logic [CNT_W-1:0]  bypass_cnt
);
    import cpu_pkg::*;

    logic                r_out_valid;
    logic [INSTR_W-1:0]  r_instr;
    logic [CNT_W-1:0]    r_bypass_cnt;

    logic                w_in_ready;
    logic                w_accept;
    logic [ADDR_W-1:0]   w_rs_addr;
    logic [ADDR_W-1:0]   w_rt_addr;
    logic                w_rs_hit;
    logic                w_rt_hit;
    logic                w_count_en;

    assign w_in_ready = (~r_out_valid | bus.out_ready) & ~bus.flush;
    assign w_accept   = bus.in_valid & w_in_ready;

    // Reading the held instruction's registers every idle/stall cycle keeps operands fresh.
    assign w_rs_addr = w_accept ? rs_field(bus.in_instr) : rs_field(r_instr);
    assign w_rt_addr = w_accept ? rt_field(bus.in_instr) : rt_field(r_instr);

    assign bus.in_ready  = w_in_ready;
    assign bus.rf_rs     = w_rs_addr;
    assign bus.rf_rt     = w_rt_addr;
    assign bus.out_valid = r_out_valid;
    assign bus.out_instr = r_instr;
    assign bypass_cnt    = r_bypass_cnt;

    rf_bypass_port #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_rs_port (
        .clk         (clk),
        .rst         (rst),
        .i_rd_addr   (w_rs_addr),
        .i_held_addr (rs_field(r_instr)),
        .i_flush     (bus.flush),
        .i_wb_we     (bus.wb_we),
        .i_wb_addr   (bus.wb_addr),
        .i_wb_data   (bus.wb_data),
        .i_rf_data   (bus.rf_rs_data),
        .o_hit       (w_rs_hit),
        .o_operand   (bus.out_a)
    );

    rf_bypass_port #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_rt_port (
        .clk         (clk),
        .rst         (rst),
        .i_rd_addr   (w_rt_addr),
        .i_held_addr (rt_field(r_instr)),
        .i_flush     (bus.flush),
        .i_wb_we     (bus.wb_we),
        .i_wb_addr   (bus.wb_addr),
        .i_wb_data   (bus.wb_data),
        .i_rf_data   (bus.rf_rt_data),
        .o_hit       (w_rt_hit),
        .o_operand   (bus.out_b)
    );

    // Output register: flush drops, accept replaces (no bubble), completion empties.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_instr     <= {INSTR_W{1'b0}};
        end else if (bus.flush) begin
            r_out_valid <= 1'b0;
            r_instr     <= r_instr;
        end else if (w_accept) begin
            r_out_valid <= 1'b1;
            r_instr     <= bus.in_instr;
        end else if (bus.out_ready) begin
            r_out_valid <= 1'b0;
            r_instr     <= r_instr;
        end else begin
            r_out_valid <= r_out_valid;
            r_instr     <= r_instr;
        end
    end

    assign w_count_en = (w_rs_hit | w_rt_hit) & (w_accept | r_out_valid)
                      & (r_bypass_cnt != {CNT_W{1'b1}});

    // Saturating count of edges that captured a bypass for a live instruction.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_bypass_cnt <= {CNT_W{1'b0}};
        end else if (w_count_en) begin
            r_bypass_cnt <= r_bypass_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            r_bypass_cnt <= r_bypass_cnt;
        end
    end

endmodule

// File: tb/tb_operand_fetch.sv
// Self-checking bench for operand_fetch: behavioural regfile, architectural
// register model, directed vector table, random traffic and async reset.
module tb_operand_fetch;

    localparam int CNT_W   = 4;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst;
    logic [CNT_W-1:0] bypass_cnt;

    operand_fetch_if bus ();

    operand_fetch #(.DATA_W(32), .ADDR_W(5), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus),
        .bypass_cnt (bypass_cnt)
    );

    always #5 clk = ~clk;

    // Registered-read register file: returns the pre-write value on a same-edge write.
    logic [31:0] rf_mem [32];
    always @(posedge clk) begin
        bus.rf_rs_data <= (bus.rf_rs == 5'd0) ? 32'd0 : rf_mem[bus.rf_rs];
        bus.rf_rt_data <= (bus.rf_rt == 5'd0) ? 32'd0 : rf_mem[bus.rf_rt];
        if (bus.wb_we && bus.wb_addr != 5'd0) rf_mem[bus.wb_addr] <= bus.wb_data;
    end

    // Reference model: architectural register values and the stage's visible state.
    logic [31:0] m_regs [32];
    bit          m_valid;
    logic [31:0] m_instr;
    int          m_cnt;

    int n_checks = 0;
    int n_err    = 0;

    typedef struct {
        bit          v;
        logic [4:0]  rs;
        logic [4:0]  rt;
        bit          ordy;
        bit          fl;
        bit          we;
        logic [4:0]  wa;
        logic [31:0] wd;
        bit          ev;
        logic [31:0] ea;
        logic [31:0] eb;
        int          ecnt;
        bit          cab;
    } vec_t;

    vec_t tbl [10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] mk(input logic [4:0] rs, input logic [4:0] rt, input logic [15:0] lo);
        return {6'h23, rs, rt, lo};
    endfunction

    function automatic logic [31:0] init_val(input int i);
        logic [31:0] v;
        v = 32'h1000_0000 + 32'(i) * 32'h0101;
        if (i == 3) v = 32'h11;
        if (i == 4) v = 32'h22;
        if (i == 5) v = 32'h0;
        return v;
    endfunction

    task automatic drive(input bit v, input logic [31:0] instr, input bit ordy, input bit fl,
                         input bit we, input logic [4:0] wa, input logic [31:0] wd);
        bus.in_valid  = v;
        bus.in_instr  = instr;
        bus.out_ready = ordy;
        bus.flush     = fl;
        bus.wb_we     = we;
        bus.wb_addr   = wa;
        bus.wb_data   = wd;
    endtask

    // One clock: compare against the model at the falling edge, then advance the model.
    task automatic cycle();
        bit         rdy, acc, hs, ht;
        logic [4:0] a_rs, a_rt;
        @(negedge clk);
        rdy  = (!m_valid || bus.out_ready) && !bus.flush;
        acc  = bus.in_valid && rdy;
        a_rs = acc ? bus.in_instr[25:21] : m_instr[25:21];
        a_rt = acc ? bus.in_instr[20:16] : m_instr[20:16];
        chk("in_ready", {31'd0, bus.in_ready}, {31'd0, rdy});
        chk("out_valid", {31'd0, bus.out_valid}, {31'd0, m_valid});
        chk("bypass_cnt", 32'(bypass_cnt), 32'(m_cnt));
        chk("rf_rs", 32'(bus.rf_rs), 32'(a_rs));
        chk("rf_rt", 32'(bus.rf_rt), 32'(a_rt));
        if (m_valid) begin
            chk("out_instr", bus.out_instr, m_instr);
            chk("out_a", bus.out_a, m_regs[m_instr[25:21]]);
            chk("out_b", bus.out_b, m_regs[m_instr[20:16]]);
        end
        hs = bus.wb_we && bus.wb_addr == a_rs && a_rs != 5'd0;
        ht = bus.wb_we && bus.wb_addr == a_rt && a_rt != 5'd0;
        if ((hs || ht) && (acc || m_valid) && m_cnt < CNT_MAX) m_cnt++;
        if (bus.wb_we && bus.wb_addr != 5'd0) m_regs[bus.wb_addr] = bus.wb_data;
        if (bus.flush)              m_valid = 1'b0;
        else if (acc)               begin m_valid = 1'b1; m_instr = bus.in_instr; end
        else if (bus.out_ready)     m_valid = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        m_valid = 1'b0;
        m_instr = 32'd0;
        m_cnt   = 0;
    endtask

    initial begin
        int nv;
        for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
        model_reset();
        rst = 1'b1;
        drive(1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0);
        repeat (3) @(posedge clk);
        #2;
        chk("reset_out_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("reset_out_instr", bus.out_instr, 32'd0);
        chk("reset_bypass_cnt", 32'(bypass_cnt), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Load the register file through the writeback port while the stage is idle.
        for (int i = 1; i < 32; i++) begin
            drive(1'b0, 32'd0, 1'b1, 1'b0, 1'b1, 5'(i), init_val(i));
            cycle();
        end

        //         v   rs    rt    rdy fl  we  wa    wd              ev  ea           eb          cnt cab
        tbl[0] = '{1'b1, 5'd3, 5'd4, 1'b1, 1'b0, 1'b0, 5'd0, 32'd0,         1'b0, 32'd0,       32'd0,      0, 1'b0};
        tbl[1] = '{1'b1, 5'd5, 5'd4, 1'b1, 1'b0, 1'b1, 5'd5, 32'h0000_DEAD, 1'b1, 32'h11,      32'h22,     0, 1'b1};
        tbl[2] = '{1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0,         1'b1, 32'hDEAD,    32'h22,     1, 1'b1};
        tbl[3] = '{1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 5'd4, 32'h99,        1'b1, 32'hDEAD,    32'h22,     1, 1'b1};
        tbl[4] = '{1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0,         1'b1, 32'hDEAD,    32'h99,     2, 1'b1};
        tbl[5] = '{1'b0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 5'd0, 32'd0,         1'b1, 32'hDEAD,    32'h99,     2, 1'b1};
        tbl[6] = '{1'b1, 5'd0, 5'd3, 1'b1, 1'b0, 1'b1, 5'd0, 32'hFFFF,      1'b0, 32'd0,       32'd0,      2, 1'b0};
        tbl[7] = '{1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 5'd0, 32'hFFFF,      1'b1, 32'd0,       32'h11,     2, 1'b1};
        tbl[8] = '{1'b1, 5'd7, 5'd7, 1'b0, 1'b1, 1'b0, 5'd0, 32'd0,         1'b1, 32'd0,       32'h11,     2, 1'b1};
        tbl[9] = '{1'b0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 5'd0, 32'd0,         1'b0, 32'd0,       32'd0,      2, 1'b0};

        for (int i = 0; i < 10; i++) begin
            drive(tbl[i].v, mk(tbl[i].rs, tbl[i].rt, 16'(i)), tbl[i].ordy, tbl[i].fl,
                  tbl[i].we, tbl[i].wa, tbl[i].wd);
            #1;
            chk($sformatf("tbl%0d_valid", i), {31'd0, bus.out_valid}, {31'd0, tbl[i].ev});
            chk($sformatf("tbl%0d_cnt", i), 32'(bypass_cnt), 32'(tbl[i].ecnt));
            if (tbl[i].cab) begin
                chk($sformatf("tbl%0d_a", i), bus.out_a, tbl[i].ea);
                chk($sformatf("tbl%0d_b", i), bus.out_b, tbl[i].eb);
            end
            cycle();
        end
        chk("tbl_stall_instr_rs", 32'(bus.out_instr[25:21]), 32'd0);

        // Eight back-to-back accepts must give eight consecutive valid cycles.
        nv = 0;
        for (int k = 0; k < 9; k++) begin
            drive(k < 8, mk(5'($urandom_range(1, 7)), 5'($urandom_range(0, 7)), 16'($urandom)),
                  1'b1, 1'b0, 1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom);
            #1;
            if (k > 0 && bus.out_valid) nv++;
            cycle();
        end
        chk("b2b_valid_cycles", 32'(nv), 32'd8);

        // Random traffic with frequent address collisions.
        for (int k = 0; k < 400; k++) begin
            drive($urandom_range(0, 3) != 0,
                  mk(5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 16'($urandom)),
                  $urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0,
                  1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom);
            cycle();
        end
        chk("cnt_saturated", 32'(bypass_cnt), 32'(CNT_MAX));

        // Asynchronous reset in the middle of a stall.
        drive(1'b1, mk(5'd6, 5'd7, 16'h0600), 1'b1, 1'b0, 1'b0, 5'd0, 32'd0);
        cycle();
        drive(1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0);
        cycle();
        #1;
        rst = 1'b1;
        #1;
        chk("async_rst_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("async_rst_cnt", 32'(bypass_cnt), 32'd0);
        chk("async_rst_instr", bus.out_instr, 32'd0);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        drive(1'b1, mk(5'd4, 5'd5, 16'h0405), 1'b1, 1'b0, 1'b0, 5'd0, 32'd0);
        cycle();
        drive(1'b0, 32'd0, 1'b1, 1'b0, 1'b0, 5'd0, 32'd0);
        #1;
        chk("resume_valid", {31'd0, bus.out_valid}, 32'd1);
        chk("resume_a", bus.out_a, m_regs[4]);
        cycle();
        cycle();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
